// File: rtl/multi_counter_rmw.sv
// Bank of N W-bit counters updated by a 2-stage read-modify-write pipeline
// with same-id forwarding, wrap/saturate arithmetic and a post-reset clear sweep.
module multi_counter_rmw #(
    parameter int unsigned N       = 16,
    parameter int unsigned W       = 32,
    parameter int unsigned DELTA_W = 8,
    parameter int unsigned SAT     = 0,
    localparam int unsigned ID_W   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [4:0]      cmd_op,
    input  logic [ID_W-1:0] cmd_id,
    input  logic [W-1:0]    cmd_dat,
    output logic            resp_vld,
    output logic [ID_W-1:0] resp_id,
    output logic [W-1:0]    resp_dat,
    output logic            evt_ovf,
    output logic [ID_W-1:0] evt_id
);

    localparam int unsigned WX = W + 1;
    localparam bit SAT_EN = (SAT != 0);

    localparam logic [4:0] OP_INIT     = 5'b0_01_00;
    localparam logic [4:0] OP_INCR     = 5'b0_11_00;
    localparam logic [4:0] OP_DECR     = 5'b0_11_01;
    localparam logic [4:0] OP_QRY      = 5'b1_10_00;
    localparam logic [4:0] OP_INCR_QRY = 5'b1_11_00;
    localparam logic [4:0] OP_DECR_QRY = 5'b1_11_01;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    typedef enum logic [1:0] {K_INIT, K_INCR, K_DECR, K_QRY} kind_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] clr_idx_q, clr_idx_d;
    logic            clr_we;
    logic            rdy_d;

    logic [W-1:0]    mem [N];

    logic            dec_legal;
    kind_t           dec_kind;

    logic            s1_vld, s1_resp;
    logic [ID_W-1:0] s1_id;
    kind_t           s1_kind;
    logic [W-1:0]    s1_dat, s1_val;

    logic            s2_vld, s2_resp, s2_ovf;
    logic [ID_W-1:0] s2_id;
    kind_t           s2_kind;
    logic [W-1:0]    s2_dat, s2_val, s2_res;
    logic [WX-1:0]   s2_delta, s2_sum, s2_diff;

    // FSM state register; clear index and ready flag ride along
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cmd_rdy   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_idx_q == ID_W'(N - 1)) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        clr_we    = 1'b0;
        clr_idx_d = clr_idx_q;
        rdy_d     = (state_d == ST_RUN);
        if (state_q == ST_CLEAR) begin
            clr_we    = 1'b1;
            clr_idx_d = clr_idx_q + ID_W'(1);
        end
    end

    // Unlisted encodings never enter the pipeline
    always_comb begin
        dec_legal = 1'b1;
        dec_kind  = K_QRY;
        case (cmd_op)
            OP_INIT:              dec_kind = K_INIT;
            OP_INCR, OP_INCR_QRY: dec_kind = K_INCR;
            OP_DECR, OP_DECR_QRY: dec_kind = K_DECR;
            OP_QRY:               dec_kind = K_QRY;
            default:              dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_resp <= 1'b0;
            s1_id   <= '0;
            s1_kind <= K_QRY;
            s1_dat  <= '0;
        end else begin
            s1_vld  <= cmd_vld & cmd_rdy & dec_legal;
            s1_resp <= cmd_op[4];
            s1_id   <= cmd_id;
            s1_kind <= dec_kind;
            s1_dat  <= cmd_dat;
        end
    end

    // Same-id op in S2 has not written yet, so take its result directly
    always_comb begin
        s1_val = mem[s1_id];
        if (s2_vld && (s2_id == s1_id)) s1_val = s2_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_resp <= 1'b0;
            s2_id   <= '0;
            s2_kind <= K_QRY;
            s2_dat  <= '0;
            s2_val  <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_resp <= s1_resp;
            s2_id   <= s1_id;
            s2_kind <= s1_kind;
            s2_dat  <= s1_dat;
            s2_val  <= s1_val;
        end
    end

    // One extra bit exposes carry/borrow independent of the saturate mode
    always_comb begin
        s2_delta = WX'(s2_dat[DELTA_W-1:0]);
        s2_sum   = {1'b0, s2_val} + s2_delta;
        s2_diff  = {1'b0, s2_val} - s2_delta;
        s2_res   = s2_val;
        s2_ovf   = 1'b0;
        case (s2_kind)
            K_INIT: s2_res = s2_dat;
            K_INCR: begin
                s2_ovf = s2_sum[W];
                s2_res = (SAT_EN && s2_ovf) ? '1 : s2_sum[W-1:0];
            end
            K_DECR: begin
                s2_ovf = s2_diff[W];
                s2_res = (SAT_EN && s2_ovf) ? '0 : s2_diff[W-1:0];
            end
            default: s2_res = s2_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx_q] <= '0;
        end else if (s2_vld && (s2_kind != K_QRY)) begin
            mem[s2_id] <= s2_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld <= 1'b0;
            resp_id  <= '0;
            resp_dat <= '0;
            evt_ovf  <= 1'b0;
            evt_id   <= '0;
        end else begin
            resp_vld <= s2_vld & s2_resp;
            evt_ovf  <= s2_vld & s2_ovf;
            if (s2_vld && s2_resp) begin
                resp_id  <= s2_id;
                resp_dat <= s2_res;
            end
            if (s2_vld && s2_ovf) evt_id <= s2_id;
        end
    end

endmodule

// File: tb/tb_multi_counter_rmw.sv
// Directed bench: a wrap-mode and a saturate-mode instance (W=8, DELTA_W=4)
// receive the same command stream and are checked against hand-computed values.
module tb_multi_counter_rmw;

    localparam int unsigned N   = 16;
    localparam int unsigned W   = 8;
    localparam int unsigned DW  = 4;
    localparam int unsigned IDW = 4;

    localparam logic [4:0] OP_INIT     = 5'b0_01_00;
    localparam logic [4:0] OP_INCR     = 5'b0_11_00;
    localparam logic [4:0] OP_DECR     = 5'b0_11_01;
    localparam logic [4:0] OP_QRY      = 5'b1_10_00;
    localparam logic [4:0] OP_INCR_QRY = 5'b1_11_00;
    localparam logic [4:0] OP_DECR_QRY = 5'b1_11_01;
    localparam logic [4:0] OP_BAD      = 5'b1_00_11;

    logic           clk;
    logic           rst_n;
    logic           cmd_vld;
    logic [4:0]     cmd_op;
    logic [IDW-1:0] cmd_id;
    logic [W-1:0]   cmd_dat;

    logic           rdy_w, rv_w, ev_w, rdy_s, rv_s, ev_s;
    logic [IDW-1:0] rid_w, eid_w, rid_s, eid_s;
    logic [W-1:0]   rdat_w, rdat_s;

    int checks = 0;
    int errors = 0;

    multi_counter_rmw #(.N(N), .W(W), .DELTA_W(DW), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(rdy_w),
        .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_dat(cmd_dat),
        .resp_vld(rv_w), .resp_id(rid_w), .resp_dat(rdat_w),
        .evt_ovf(ev_w), .evt_id(eid_w)
    );

    multi_counter_rmw #(.N(N), .W(W), .DELTA_W(DW), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(rdy_s),
        .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_dat(cmd_dat),
        .resp_vld(rv_s), .resp_id(rid_s), .resp_dat(rdat_s),
        .evt_ovf(ev_s), .evt_id(eid_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [IDW-1:0] id, input logic [W-1:0] dat);
        cmd_vld = 1'b1;
        cmd_op  = op;
        cmd_id  = id;
        cmd_dat = dat;
    endtask

    task automatic idle();
        cmd_vld = 1'b0;
        cmd_op  = 5'b0;
        cmd_id  = '0;
        cmd_dat = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        checks++;
        if ({rv_w, rv_s, ev_w, ev_s, rdy_w, rdy_s} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 000000", {rv_w, rv_s, ev_w, ev_s, rdy_w, rdy_s});
        end
        checks++;
        if ({rid_w, rdat_w, eid_w, rid_s, rdat_s, eid_s} !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {rid_w, rdat_w, eid_w, rid_s, rdat_s, eid_s});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rdy_w, rdy_s, rv_w, rv_s} !== 4'b0) begin
                errors++;
                $display("FAIL clear_rdy cyc=%0d got %b exp 0000", i, {rdy_w, rdy_s, rv_w, rv_s});
            end
            step();
        end
        checks++;
        if ({rdy_w, rdy_s} !== 2'b11) begin
            errors++;
            $display("FAIL run_rdy got %b exp 11", {rdy_w, rdy_s});
        end
    endtask

    task automatic test_clear_query();
        for (int c = 0; c < 19; c++) begin
            logic e_rv;
            e_rv = (c >= 3);
            checks++;
            if ({rv_w, rv_s} !== {e_rv, e_rv}) begin
                errors++;
                $display("FAIL clrq_vld c=%0d got %b exp %b", c, {rv_w, rv_s}, {e_rv, e_rv});
            end
            if (e_rv) begin
                checks++;
                if ({rid_w, rdat_w, rid_s, rdat_s} !== {IDW'(c - 3), 8'd0, IDW'(c - 3), 8'd0}) begin
                    errors++;
                    $display("FAIL clrq_dat c=%0d got id=%0d/%0d dat=%0d/%0d exp id=%0d dat=0",
                             c, rid_w, rid_s, rdat_w, rdat_s, c - 3);
                end
            end
            checks++;
            if ({ev_w, ev_s} !== 2'b00) begin
                errors++;
                $display("FAIL clrq_evt c=%0d got %b exp 00", c, {ev_w, ev_s});
            end
            if (c < 16) drive(OP_QRY, IDW'(c), 8'd0);
            else idle();
            step();
        end
    endtask

    task automatic test_forward();
        logic [4:0] ops [3];
        logic [7:0] dats [3];
        ops  = '{OP_INIT, OP_INCR, OP_QRY};
        dats = '{8'd100, 8'hF5, 8'h00};
        for (int c = 0; c < 6; c++) begin
            logic e_rv;
            e_rv = (c == 5);
            checks++;
            if ({rv_w, rv_s} !== {e_rv, e_rv}) begin
                errors++;
                $display("FAIL fwd_vld c=%0d got %b exp %b", c, {rv_w, rv_s}, {e_rv, e_rv});
            end
            if (e_rv) begin
                checks++;
                if ({rid_w, rdat_w, rid_s, rdat_s} !== {4'd3, 8'd105, 4'd3, 8'd105}) begin
                    errors++;
                    $display("FAIL fwd_dat got id=%0d/%0d dat=%0d/%0d exp id=3 dat=105",
                             rid_w, rid_s, rdat_w, rdat_s);
                end
            end
            checks++;
            if ({ev_w, ev_s} !== 2'b00) begin
                errors++;
                $display("FAIL fwd_evt c=%0d got %b exp 00", c, {ev_w, ev_s});
            end
            if (c < 3) drive(ops[c], 4'd3, dats[c]);
            else idle();
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            logic e_rv;
            e_rv = (c >= 3);
            checks++;
            if ({rv_w, rv_s} !== {e_rv, e_rv}) begin
                errors++;
                $display("FAIL b2b_vld c=%0d got %b exp %b", c, {rv_w, rv_s}, {e_rv, e_rv});
            end
            if (e_rv) begin
                checks++;
                if ({rid_w, rdat_w, rid_s, rdat_s} !== {4'd7, 8'(c - 2), 4'd7, 8'(c - 2)}) begin
                    errors++;
                    $display("FAIL b2b_dat c=%0d got id=%0d/%0d dat=%0d/%0d exp id=7 dat=%0d",
                             c, rid_w, rid_s, rdat_w, rdat_s, c - 2);
                end
            end
            checks++;
            if ({ev_w, ev_s} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_evt c=%0d got %b exp 00", c, {ev_w, ev_s});
            end
            if (c < 4) drive(OP_INCR_QRY, 4'd7, 8'd1);
            else idle();
            step();
        end
    endtask

    task automatic test_ovf_sat();
        logic [4:0]     ops [9];
        logic [IDW-1:0] ids [9];
        logic [7:0]     dats [9];
        logic           erv [9];
        logic [7:0]     edw [9];
        logic [7:0]     eds [9];
        logic           eew [9];
        logic           ees [9];
        ops  = '{OP_INIT, OP_INCR, OP_QRY, OP_DECR_QRY, OP_BAD, OP_QRY, OP_INCR_QRY, OP_INCR_QRY, OP_DECR};
        ids  = '{4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2};
        dats = '{8'd250, 8'd10, 8'd0, 8'd1, 8'h07, 8'd0, 8'h30, 8'h0F, 8'h13};
        erv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        edw  = '{8'd0, 8'd0, 8'd4, 8'd255, 8'd0, 8'd255, 8'd255, 8'd19, 8'd0};
        eds  = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0};
        eew  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ees  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 12; c++) begin
            int i;
            logic e_rv, e_ew, e_es;
            logic [7:0] dw, ds;
            logic [IDW-1:0] eid;
            i = c - 3;
            e_rv = 1'b0; e_ew = 1'b0; e_es = 1'b0; dw = '0; ds = '0; eid = '0;
            if (i >= 0) begin
                e_rv = erv[i]; e_ew = eew[i]; e_es = ees[i];
                dw = edw[i]; ds = eds[i]; eid = ids[i];
            end
            checks++;
            if ({rv_w, rv_s} !== {e_rv, e_rv}) begin
                errors++;
                $display("FAIL ovf_vld c=%0d got %b exp %b", c, {rv_w, rv_s}, {e_rv, e_rv});
            end
            if (e_rv) begin
                checks++;
                if ({rid_w, rdat_w} !== {eid, dw}) begin
                    errors++;
                    $display("FAIL ovf_dat_wrap c=%0d got id=%0d dat=%0d exp id=%0d dat=%0d",
                             c, rid_w, rdat_w, eid, dw);
                end
                checks++;
                if ({rid_s, rdat_s} !== {eid, ds}) begin
                    errors++;
                    $display("FAIL ovf_dat_sat c=%0d got id=%0d dat=%0d exp id=%0d dat=%0d",
                             c, rid_s, rdat_s, eid, ds);
                end
            end
            checks++;
            if ({ev_w, ev_s} !== {e_ew, e_es}) begin
                errors++;
                $display("FAIL ovf_evt c=%0d got %b exp %b", c, {ev_w, ev_s}, {e_ew, e_es});
            end
            if (e_ew) begin
                checks++;
                if (eid_w !== eid) begin
                    errors++;
                    $display("FAIL ovf_eid_wrap c=%0d got %0d exp %0d", c, eid_w, eid);
                end
            end
            if (e_es) begin
                checks++;
                if (eid_s !== eid) begin
                    errors++;
                    $display("FAIL ovf_eid_sat c=%0d got %0d exp %0d", c, eid_s, eid);
                end
            end
            if (c < 9) drive(ops[c], ids[c], dats[c]);
            else idle();
            step();
        end
        // last response came from id2; the trailing DECR must not disturb it
        checks++;
        if ({rv_w, rv_s, rid_w, rdat_w, rid_s, rdat_s} !== {2'b00, 4'd2, 8'd19, 4'd2, 8'd255}) begin
            errors++;
            $display("FAIL hold got vld=%b id=%0d/%0d dat=%0d/%0d exp vld=00 id=2 dat=19/255",
                     {rv_w, rv_s}, rid_w, rid_s, rdat_w, rdat_s);
        end
    endtask

    task automatic test_reset_mid();
        drive(OP_INCR, 4'd4, 8'd3);
        step();
        drive(OP_INCR_QRY, 4'd4, 8'd1);
        step();
        rst_n = 1'b0;
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rv_w, rv_s, ev_w, ev_s, rdy_w, rdy_s} !== 6'b0) begin
                errors++;
                $display("FAIL midrst_ctl k=%0d got %b exp 000000", k, {rv_w, rv_s, ev_w, ev_s, rdy_w, rdy_s});
            end
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rdy_w, rdy_s, rv_w, rv_s, ev_w, ev_s} !== 6'b0) begin
                errors++;
                $display("FAIL midrst_clear cyc=%0d got %b exp 000000", i, {rdy_w, rdy_s, rv_w, rv_s, ev_w, ev_s});
            end
            step();
        end
        checks++;
        if ({rdy_w, rdy_s} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_rdy got %b exp 11", {rdy_w, rdy_s});
        end
    endtask

    initial begin
        test_reset();
        test_clear_query();
        test_forward();
        test_back_to_back();
        test_ovf_sat();
        test_reset_mid();
        test_clear_query();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
